// File: rtl/pe_ctrl_pkg.sv
// Shared types, codes and sizes for the PE-array scan controller.
// Optional SEARCH_ABORT_EN support lives in pe_array_scan_ctrl.
package pe_ctrl_pkg;

  localparam int unsigned CB_NUM         = 3;
  localparam int unsigned BLK_PIX        = 64;
  localparam int unsigned REF_FILL_BEATS = 8;
  localparam int unsigned SR_ROWS        = 8;
  localparam int unsigned SR_COLS        = 8;

  localparam int unsigned NCB_W   = 2;
  localparam int unsigned SLOT_W  = 3;
  localparam int unsigned COORD_W = 3;
  localparam int unsigned PIX_W   = $clog2(BLK_PIX);
  localparam int unsigned FILL_W  = $clog2(REF_FILL_BEATS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_CURR,
    REF_FILL,
    SEARCH,
    DONE
  } state_e;

  localparam logic [1:0] REF_UP1 = 2'b00;
  localparam logic [1:0] REF_UP8 = 2'b01;
  localparam logic [1:0] REF_DN1 = 2'b10;
  localparam logic [1:0] REF_DN8 = 2'b11;

  // Zero slots requested means one; never exceed the physical slot count.
  function automatic logic [SLOT_W-1:0] clamp_cb(input logic [NCB_W-1:0] ncb);
    if (ncb == '0) return SLOT_W'(1);
    if (32'(ncb) > CB_NUM) return SLOT_W'(CB_NUM);
    return SLOT_W'(ncb);
  endfunction

endpackage

// File: rtl/pe_snake_scan.sv
// Snake-order candidate walker: down even columns, up odd columns, step right at column end.
module pe_snake_scan
  import pe_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               step,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic [1:0]         ref_code,
  output logic               last
);

  logic row_end;

  always_comb begin
    row_end = col[0] ? (row == '0) : (row == COORD_W'(SR_ROWS - 1));
    last    = row_end && (col == COORD_W'(SR_COLS - 1));
    if (row_end)     ref_code = REF_DN8;
    else if (col[0]) ref_code = REF_UP1;
    else             ref_code = REF_DN1;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (step && !last) begin
      if (row_end)     col <= col + COORD_W'(1);
      else if (col[0]) row <= row - COORD_W'(1);
      else             row <= row + COORD_W'(1);
    end
  end

endmodule

// File: rtl/pe_array_scan_ctrl.sv
// Load / reference-fill / snake-search sequencer for the current/reference PE chain.
// Define SEARCH_ABORT_EN to add the abort input and aborted output.
module pe_array_scan_ctrl
  import pe_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NCB_W-1:0]   num_cb,
  input  logic               curr_valid,
`ifdef SEARCH_ABORT_EN
  input  logic               abort,
`endif
  output logic               curr_ready,
  output logic               in_curr_enable,
  output logic [SLOT_W-1:0]  CB_select,
  output logic               change_curr,
  output logic               change_ref,
  output logic [1:0]         ref_input_Control,
  output logic [SLOT_W-1:0]  abs_Control,
  output logic               sad_valid,
  output logic [COORD_W-1:0] cand_row,
  output logic [COORD_W-1:0] cand_col,
  output logic               busy,
`ifdef SEARCH_ABORT_EN
  output logic               aborted,
`endif
  output logic               done
);

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   n_q, slot_q, k_q;
  logic [PIX_W-1:0]    pix_q;
  logic [FILL_W-1:0]   fill_q;
  logic                accept, pix_last, slot_last, fill_last, k_last;
  logic                abort_hit, scan_step, scan_clear, scan_last;
  logic [1:0]          scan_code;

  always_comb begin
    accept    = curr_valid && (state_q == LOAD_CURR);
    pix_last  = (pix_q == PIX_W'(BLK_PIX - 1));
    slot_last = (slot_q == n_q - SLOT_W'(1));
    fill_last = (fill_q == FILL_W'(REF_FILL_BEATS - 1));
    k_last    = (k_q == n_q - SLOT_W'(1));
  end

`ifdef SEARCH_ABORT_EN
  logic aborted_q;
  assign abort_hit = abort && ((state_q == LOAD_CURR) || (state_q == REF_FILL) ||
                               (state_q == SEARCH));
  always_ff @(posedge clk) begin
    if (rst) aborted_q <= 1'b0;
    else     aborted_q <= abort_hit;
  end
`else
  assign abort_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start) state_d = LOAD_CURR;
      LOAD_CURR: if (accept && pix_last && slot_last) state_d = REF_FILL;
      REF_FILL:  if (fill_last) state_d = SEARCH;
      SEARCH:    if (k_last && scan_last) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (abort_hit) state_d = DONE;
  end

  // Pixel, slot, fill and abs-slot counters
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q    <= '0;
      slot_q <= '0;
      pix_q  <= '0;
      fill_q <= '0;
      k_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          slot_q <= '0;
          pix_q  <= '0;
          fill_q <= '0;
          k_q    <= '0;
          if (start) n_q <= clamp_cb(num_cb);
        end
        LOAD_CURR: begin
          if (accept) begin
            if (pix_last) begin
              pix_q  <= '0;
              slot_q <= slot_q + SLOT_W'(1);
            end else begin
              pix_q <= pix_q + PIX_W'(1);
            end
          end
        end
        REF_FILL: fill_q <= fill_last ? '0 : fill_q + FILL_W'(1);
        SEARCH:   k_q <= k_last ? '0 : k_q + SLOT_W'(1);
        default: begin
          slot_q <= '0;
          pix_q  <= '0;
          fill_q <= '0;
          k_q    <= '0;
        end
      endcase
    end
  end

  // Move to the next candidate only when the search actually continues.
  assign scan_step  = (state_q == SEARCH) && k_last && (state_d == SEARCH);
  assign scan_clear = (state_q == REF_FILL);

  pe_snake_scan u_scan (
    .clk      (clk),
    .rst      (rst),
    .clear    (scan_clear),
    .step     (scan_step),
    .row      (cand_row),
    .col      (cand_col),
    .ref_code (scan_code),
    .last     (scan_last)
  );

  // Output decode
  always_comb begin
    curr_ready        = 1'b0;
    in_curr_enable    = 1'b0;
    CB_select         = '0;
    change_curr       = 1'b0;
    change_ref        = 1'b0;
    ref_input_Control = REF_UP1;
    abs_Control       = '0;
    sad_valid         = 1'b0;
    busy              = (state_q != IDLE);
    done              = 1'b0;
`ifdef SEARCH_ABORT_EN
    aborted           = 1'b0;
`endif
    unique case (state_q)
      LOAD_CURR: begin
        curr_ready     = 1'b1;
        in_curr_enable = curr_valid;
        CB_select      = slot_q;
      end
      REF_FILL: begin
        change_ref        = 1'b1;
        ref_input_Control = REF_DN1;
      end
      SEARCH: begin
        sad_valid   = 1'b1;
        abs_Control = k_q;
        // (0,0) with slot 0 only occurs on the SEARCH entry cycle.
        change_curr = (k_q == '0) && (cand_row == '0) && (cand_col == '0);
        if (k_last && !scan_last) begin
          change_ref        = 1'b1;
          ref_input_Control = scan_code;
        end
      end
      DONE: begin
        done = 1'b1;
`ifdef SEARCH_ABORT_EN
        aborted = aborted_q;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pe_array_scan_ctrl.sv
// Self-checking bench for pe_array_scan_ctrl: count-level model plus literal pins.
module tb_pe_array_scan_ctrl;

  localparam int BLK = 64, RFILL = 8, ROWS = 8, COLS = 8;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, curr_valid = 1'b0, abort = 1'b0;
  logic [1:0] num_cb = 2'd0;
  logic       curr_ready, in_curr_enable, change_curr, change_ref, sad_valid, busy, done, aborted;
  logic [2:0] CB_select, abs_Control, cand_row, cand_col;
  logic [1:0] ref_input_Control;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  pe_array_scan_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .num_cb            (num_cb),
    .curr_valid        (curr_valid),
`ifdef SEARCH_ABORT_EN
    .abort             (abort),
`endif
    .curr_ready        (curr_ready),
    .in_curr_enable    (in_curr_enable),
    .CB_select         (CB_select),
    .change_curr       (change_curr),
    .change_ref        (change_ref),
    .ref_input_Control (ref_input_Control),
    .abs_Control       (abs_Control),
    .sad_valid         (sad_valid),
    .cand_row          (cand_row),
    .cand_col          (cand_col),
    .busy              (busy),
`ifdef SEARCH_ABORT_EN
    .aborted           (aborted),
`endif
    .done              (done)
  );

`ifndef SEARCH_ABORT_EN
  assign aborted = 1'b0;
`endif

  wire [21:0] all_outs = {busy, done, curr_ready, in_curr_enable, CB_select, change_curr,
                          change_ref, ref_input_Control, abs_Control, sad_valid,
                          cand_row, cand_col, aborted};

  // ---------------- behavioural model ----------------
  int         m_ph = 0, m_n = 1, m_beats = 0, m_fill = 0, m_t = 0;
  logic [2:0] m_cr = 3'd0, m_cc = 3'd0;
  bit         m_ab = 1'b0, cmp_en = 1'b0;

  function automatic logic [5:0] coords(input int t, input int n);
    int c, col, r, row;
    c   = t / n;
    col = c / ROWS;
    r   = c % ROWS;
    row = (col % 2 == 0) ? r : ROWS - 1 - r;
    return {3'(row), 3'(col)};
  endfunction

  always @(posedge clk) begin : model
    bit ab;
    if (rst) begin
      m_ph = 0; m_beats = 0; m_fill = 0; m_t = 0; m_cr = 3'd0; m_cc = 3'd0; m_ab = 1'b0;
    end else begin
      ab = abort && (m_ph >= 1) && (m_ph <= 3);
      if (m_ph == 3) {m_cr, m_cc} = coords(m_t, m_n);
      case (m_ph)
        0: if (start) begin
             m_ph = 1; m_beats = 0;
             m_n = (num_cb == 2'd0) ? 1 : ((int'(num_cb) > 3) ? 3 : int'(num_cb));
           end
        1: if (curr_valid) begin
             m_beats++;
             if (m_beats == m_n * BLK) begin m_ph = 2; m_fill = 0; end
           end
        2: begin m_fill++; if (m_fill == RFILL) begin m_ph = 3; m_t = 0; end end
        3: begin m_t++; if (m_t == ROWS * COLS * m_n) m_ph = 4; end
        default: m_ph = 0;
      endcase
      m_ab = ab;
      if (ab) m_ph = 4;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin : compare
    logic [21:0] act, expv;
    logic [2:0]  e_cb, e_abs, a_cb, a_abs;
    logic [1:0]  e_ref, a_ref, code;
    logic [5:0]  e_cand, a_cand;
    bit          sh, e_cr;
    int          slot, c, r, col;
    if (cmp_en) begin
      sh = 1'b0; code = 2'd0; slot = 0;
      if (m_ph == 3) begin
        slot = m_t % m_n;
        c    = m_t / m_n;
        r    = c % ROWS;
        col  = c / ROWS;
        sh   = (slot == m_n - 1) && (c != ROWS * COLS - 1);
        code = (r == ROWS - 1) ? 2'd3 : ((col % 2 == 0) ? 2'd2 : 2'd0);
      end
      e_cb   = (m_ph == 1) ? 3'(m_beats / BLK) : 3'd0;
      e_cr   = (m_ph == 2) || sh;
      e_ref  = (m_ph == 2) ? 2'd2 : (sh ? code : 2'd0);
      e_abs  = (m_ph == 3) ? 3'(slot) : 3'd0;
      e_cand = (m_ph == 3) ? coords(m_t, m_n) : ((m_ph == 4) ? {m_cr, m_cc} : 6'd0);
      a_cb   = (m_ph == 1) ? CB_select : 3'd0;
      a_ref  = e_cr ? ref_input_Control : 2'd0;
      a_abs  = (m_ph == 3) ? abs_Control : 3'd0;
      a_cand = (m_ph == 3 || m_ph == 4) ? {cand_row, cand_col} : 6'd0;
      expv = {m_ph != 0, m_ph == 4, m_ph == 1, (m_ph == 1) && curr_valid, e_cb,
              (m_ph == 3) && (m_t == 0), e_cr, e_ref, e_abs, m_ph == 3, e_cand,
              (m_ph == 4) && m_ab};
      act  = {busy, done, curr_ready, in_curr_enable, a_cb, change_curr, change_ref,
              a_ref, a_abs, sad_valid, a_cand, aborted};
      checks++;
      if (act !== expv) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t phase=%0d act=%h exp=%h", $time, m_ph, act, expv);
      end
    end
  end

  // ---------------- stimulus ----------------
  int         r_lat, r_load, r_en, r_fill, r_sad, r_absmax;
  int         r_cb[4];
  bit         r_ab;
  logic [1:0] r_codes[$];
  logic [5:0] r_cand[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, expv);
    end
  endtask

  // mode 0: valid always, 1: valid on even cycle index, 2: random valid and stray starts
  task automatic run_seq(input logic [1:0] ncb, input int mode, input int abort_at,
                         input int rst_at);
    r_lat = -1; r_load = 0; r_en = 0; r_fill = 0; r_sad = 0; r_absmax = 0; r_ab = 1'b0;
    for (int i = 0; i < 4; i++) r_cb[i] = 0;
    r_codes.delete();
    r_cand.delete();
    num_cb = ncb; start = 1'b1; curr_valid = 1'b0;
    step();
    start = 1'b0;
    for (int idx = 1; idx <= 3000; idx++) begin
      if (rst_at >= 0 && r_sad == rst_at) begin
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("rst_mid_search_outputs", int'(all_outs), 0);
        rst = 1'b0;
        step();
        r_lat = -2;
        break;
      end
      curr_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (idx % 2 == 0)
                                                   : ($urandom_range(0, 3) != 0);
      start = (mode == 2) ? ($urandom_range(0, 15) == 0) : 1'b0;
      abort = (abort_at > 0) && (r_sad == abort_at);
      if (abort) start = 1'b1;
      @(negedge clk);
      if (curr_ready) begin
        r_load++;
        if (CB_select < 3'd4) r_cb[CB_select]++;
      end
      if (in_curr_enable) r_en++;
      if (change_ref && !sad_valid && busy) r_fill++;
      if (sad_valid) begin
        r_sad++;
        if (int'(abs_Control) > r_absmax) r_absmax = int'(abs_Control);
        r_cand.push_back({cand_row, cand_col});
        if (change_ref) r_codes.push_back(ref_input_Control);
      end
      if (done) begin
        r_lat = idx;
        r_ab  = aborted;
        step();
        break;
      end
      step();
    end
    start = 1'b0; curr_valid = 1'b0; abort = 1'b0;
    if (rst_at < 0) chk("sequence_reached_done", (r_lat > 0) ? 1 : 0, 1);
  endtask

  initial begin
    int bad, nn;
    logic [1:0] ncb;
    repeat (3) step();
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_outputs", int'(all_outs), 0);
    rst = 1'b0;
    step();
    step();

    // num_cb=3, valid always
    run_seq(2'd3, 0, -1, -1);
    chk("t1_done_latency", r_lat, 1 + 192 + 8 + 192);
    chk("t1_load_cycles", r_load, 192);
    chk("t1_cb0", r_cb[0], 64);
    chk("t1_cb1", r_cb[1], 64);
    chk("t1_cb2", r_cb[2], 64);
    chk("t1_fill_cycles", r_fill, 8);
    chk("t1_search_cycles", r_sad, 192);
    chk("t1_abs_max", r_absmax, 2);
    step();

    // num_cb=0 behaves as one slot
    run_seq(2'd0, 0, -1, -1);
    chk("t2_done_latency", r_lat, 1 + 64 + 8 + 64);
    chk("t2_load_beats", r_en, 64);
    chk("t2_search_cycles", r_sad, 64);
    chk("t2_abs_max", r_absmax, 0);
    step();

    // curr_valid toggling during load
    run_seq(2'd1, 1, -1, -1);
    chk("t3_load_beats", r_en, 64);
    chk("t3_load_cycles", r_load, 128);
    chk("t3_done_latency", r_lat, 1 + 128 + 8 + 64);
    step();

    // snake order with one slot
    run_seq(2'd1, 0, -1, -1);
    chk("t4_shift_count", r_codes.size(), 63);
    if (r_codes.size() >= 16) begin
      bad = 0;
      for (int i = 0; i < 7; i++) if (r_codes[i] != 2'b10) bad++;
      chk("t4_col0_down1", bad, 0);
      chk("t4_col0_end_code", int'(r_codes[7]), 3);
      bad = 0;
      for (int i = 8; i < 15; i++) if (r_codes[i] != 2'b00) bad++;
      chk("t4_col1_up1", bad, 0);
      chk("t4_col1_end_code", int'(r_codes[15]), 3);
    end
    if (r_cand.size() == 64) begin
      chk("t4_cand_7_0", int'(r_cand[7]), int'({3'd7, 3'd0}));
      chk("t4_cand_8_is_7_1", int'(r_cand[8]), int'({3'd7, 3'd1}));
      chk("t4_cand_56_is_7_7", int'(r_cand[56]), int'({3'd7, 3'd7}));
      chk("t4_cand_63_is_0_7", int'(r_cand[63]), int'({3'd0, 3'd7}));
    end else begin
      chk("t4_cand_count", r_cand.size(), 64);
    end
    step();

    // randomized runs
    for (int k = 0; k < 6; k++) begin
      ncb = 2'($urandom_range(0, 3));
      nn  = (ncb == 2'd0) ? 1 : int'(ncb);
      run_seq(ncb, 2, -1, -1);
      chk("rand_load_beats", r_en, nn * BLK);
      chk("rand_search_cycles", r_sad, nn * ROWS * COLS);
      repeat ($urandom_range(0, 3)) step();
    end

    // reset mid-search, then a fresh sequence
    run_seq(2'd2, 0, -1, 20);
    step();
    run_seq(2'd2, 0, -1, -1);
    chk("t5_done_latency", r_lat, 1 + 128 + 8 + 128);
    chk("t5_search_cycles", r_sad, 128);
    step();

`ifdef SEARCH_ABORT_EN
    // abort on search cycle 10, with a start issued alongside
    run_seq(2'd3, 0, 10, -1);
    chk("t6_done_latency", r_lat, 1 + 192 + 8 + 11);
    chk("t6_aborted_with_done", int'(r_ab), 1);
    chk("t6_search_cycles", r_sad, 11);
    @(negedge clk);
    chk("t6_idle_after_abort", int'(busy), 0);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
